alu_share_ctrl: RTL
===================

// Module: alu_share_ctrl
// PURPOSE
//  Sequencer/arbiter sharing the single 19-bit combinational ALU (ALUControl 3b, flags {Z,O,N}) between two requesters
//  (0 = core datapath, 1 = coprocessor/debug port). Round-robin grant, valid/ready handshakes, registered ALU operands,
//  per-op multi-cycle settle wait (MULT/DIV/MOD long paths), registered result+flags returned to the granted requester.
// PARAMETERS
//  W         19  operand/result width
//  LAT_SHORT 1   settle cycles for SUM/RES/CLI/TRFI (000,001,101,110); must be >=1
//  LAT_LONG  4   settle cycles for MULT/DIV/MOD (010,011,100); must be >=LAT_SHORT
// PORTS
//  clk           in  1   clock, rising edge
//  rst_n         in  1   asynchronous active-low reset
//  req_valid0/1  in  1   request present (A/B/op must hold stable while valid && !ready)
//  req_ready0/1  out 1   request accepted this cycle when valid&&ready
//  req_a0/1      in  W   operand A
//  req_b0/1      in  W   operand B
//  req_op0/1     in  3   ALUControl code
//  rsp_valid0/1  out 1   response held valid until rsp_ready
//  rsp_ready0/1  in  1   requester takes response
//  rsp_result    out W   registered ALU Result (shared, qualify with rsp_validN)
//  rsp_flags     out 3   registered ALUFlags {Z,O,N}
//  rsp_err       out 1   1 = illegal op 3'b111, result/flags forced 0
//  alu_a, alu_b  out W   registered operands to ALU
//  alu_ctrl      out 3   registered ALUControl to ALU
//  alu_result    in  W   ALU Result
//  alu_flags     in  3   ALU flags
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE, all outputs 0, lat counter 0, rr pointer last=1 (req0 wins first); op in flight dropped.
//  FSM IDLE -> EXEC -> RESP -> IDLE; one op outstanding at a time.
//  IDLE: grant = only valid requester, or if both valid the one != last. req_readyN=1 combinationally for granted N only,
//   never outside IDLE. On accept: alu_a/b/ctrl <= req fields, last <= N, owner <= N, cnt <= LAT(op)-1, ->EXEC.
//  Illegal op 3'b111: accepted normally, ALU not driven (alu_ctrl stays at previous value), skip EXEC:
//   rsp_result=0, rsp_flags=0, rsp_err=1, ->RESP next cycle.
//  EXEC: hold alu_*; cnt decrements each cycle; at cnt==0 capture alu_result/alu_flags into rsp_*, rsp_err=0, ->RESP.
//  Latency: accepted at edge T -> rsp_valid rises at edge T+LAT(op); LAT_SHORT=1 gives result 1 cycle after accept.
//  RESP: rsp_valid[owner]=1, other rsp_valid=0; rsp_* stable until rsp_ready[owner]; on handshake -> IDLE, rsp_valid=0
//   same edge. Next accept earliest the cycle after (max throughput 1 op per LAT+2 cycles).
//  rsp_ready of non-owner ignored. req_valid changes during EXEC/RESP have no effect.
//  Flags passed through unmodified; controller does no arithmetic, no width change.
//  Counter width $clog2(LAT_LONG+1); no wrap possible (loaded <= LAT_LONG-1).
// CONFIGURATION
//  ALU_SHARE_STATS_EN defined: adds outputs grant_cnt0/1 (16b, out): +1 per accept of requester N, saturate at 16'hFFFF,
//   cleared by reset only. Not defined: ports absent, no counters; all other behaviour identical.
// TESTING
//  T1 req0 A=5 B=3 op=000, rsp_ready=1 -> rsp_valid0 at accept+1, result=8, flags=3'b000, rsp_err=0.
//  T2 req1 A=2 B=5 op=001 -> result=19'h7FFFD, flags={0,0,1}; A=7 B=7 op=001 -> result=0, flags Z=1.
//  T3 both valid continuously, ops 000 -> grants 0,1,0,1...; first grant 0 after reset; never both ready.
//  T4 req0 A=20 B=6 op=011 (LAT_LONG=4) -> rsp_valid0 exactly 4 cycles after accept, result=3; op=100 -> result=2.
//  T5 op=3'b111 -> rsp_err=1, result=0, flags=0 at accept+1; rsp_ready held 0 for 5 cycles -> rsp stable, no new grant.
//  T6 rst_n low mid-EXEC of DIV -> all outputs 0 immediately; after release, pending req0 re-granted first, no stale rsp.

Source files
------------

// File: rtl/alu_share_ctrl.sv
// Round-robin sequencer sharing one combinational ALU between two requesters.
// Optional per-requester accept counters when ALU_SHARE_STATS_EN is defined.
module alu_share_ctrl #(
  parameter int unsigned W         = 19,
  parameter int unsigned LAT_SHORT = 1,
  parameter int unsigned LAT_LONG  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         req_valid0,
  output logic         req_ready0,
  input  logic [W-1:0] req_a0,
  input  logic [W-1:0] req_b0,
  input  logic [2:0]   req_op0,
  input  logic         req_valid1,
  output logic         req_ready1,
  input  logic [W-1:0] req_a1,
  input  logic [W-1:0] req_b1,
  input  logic [2:0]   req_op1,
  output logic         rsp_valid0,
  input  logic         rsp_ready0,
  output logic         rsp_valid1,
  input  logic         rsp_ready1,
  output logic [W-1:0] rsp_result,
  output logic [2:0]   rsp_flags,
  output logic         rsp_err,
  output logic [W-1:0] alu_a,
  output logic [W-1:0] alu_b,
  output logic [2:0]   alu_ctrl,
  input  logic [W-1:0] alu_result,
  input  logic [2:0]   alu_flags
`ifdef ALU_SHARE_STATS_EN
  ,
  output logic [15:0]  grant_cnt0,
  output logic [15:0]  grant_cnt1
`endif
);

  localparam int unsigned CNT_W  = $clog2(LAT_LONG + 1);
  localparam logic [2:0]  OP_ILL = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             owner_q, owner_d;
  logic             ill_q, ill_d;
  logic [W-1:0]     alu_a_q, alu_a_d;
  logic [W-1:0]     alu_b_q, alu_b_d;
  logic [2:0]       alu_ctrl_q, alu_ctrl_d;
  logic             rsp_valid0_q, rsp_valid0_d;
  logic             rsp_valid1_q, rsp_valid1_d;
  logic [W-1:0]     rsp_result_q, rsp_result_d;
  logic [2:0]       rsp_flags_q, rsp_flags_d;
  logic             rsp_err_q, rsp_err_d;

  logic             gnt0, gnt1, acc, sel;
  logic [W-1:0]     sel_a, sel_b;
  logic [2:0]       sel_op;
  logic             sel_long;

  // Round robin: a lone requester wins; on contention the one not served last wins.
  assign gnt0     = req_valid0 && (!req_valid1 || last_q);
  assign gnt1     = req_valid1 && (!req_valid0 || !last_q);
  assign acc      = (state_q == S_IDLE) && (gnt0 || gnt1);
  assign sel      = gnt1;
  assign sel_a    = sel ? req_a1 : req_a0;
  assign sel_b    = sel ? req_b1 : req_b0;
  assign sel_op   = sel ? req_op1 : req_op0;
  assign sel_long = (sel_op == 3'b010) || (sel_op == 3'b011) || (sel_op == 3'b100);

  // Ready is held low during reset so every output reads 0 while rst_n is asserted.
  assign req_ready0 = rst_n && (state_q == S_IDLE) && gnt0;
  assign req_ready1 = rst_n && (state_q == S_IDLE) && gnt1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_d       = last_q;
    owner_d      = owner_q;
    ill_d        = ill_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctrl_d   = alu_ctrl_q;
    rsp_valid0_d = rsp_valid0_q;
    rsp_valid1_d = rsp_valid1_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (acc) begin
          last_d  = sel;
          owner_d = sel;
          state_d = S_EXEC;
          // Illegal ops leave the ALU untouched and report after one cycle.
          if (sel_op == OP_ILL) begin
            ill_d = 1'b1;
            cnt_d = CNT_W'(0);
          end else begin
            ill_d      = 1'b0;
            alu_a_d    = sel_a;
            alu_b_d    = sel_b;
            alu_ctrl_d = sel_op;
            cnt_d      = sel_long ? CNT_W'(LAT_LONG - 1) : CNT_W'(LAT_SHORT - 1);
          end
        end
      end

      S_EXEC: begin
        if (cnt_q == '0) begin
          if (ill_q) begin
            rsp_result_d = '0;
            rsp_flags_d  = 3'b000;
            rsp_err_d    = 1'b1;
          end else begin
            rsp_result_d = alu_result;
            rsp_flags_d  = alu_flags;
            rsp_err_d    = 1'b0;
          end
          rsp_valid0_d = !owner_q;
          rsp_valid1_d = owner_q;
          state_d      = S_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_RESP: begin
        if (owner_q ? rsp_ready1 : rsp_ready0) begin
          rsp_valid0_d = 1'b0;
          rsp_valid1_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: begin
        state_d      = S_IDLE;
        rsp_valid0_d = 1'b0;
        rsp_valid1_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      ill_q        <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctrl_q   <= 3'b000;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 3'b000;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      ill_q        <= ill_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctrl_q   <= alu_ctrl_d;
      rsp_valid0_q <= rsp_valid0_d;
      rsp_valid1_q <= rsp_valid1_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_ctrl   = alu_ctrl_q;
  assign rsp_valid0 = rsp_valid0_q;
  assign rsp_valid1 = rsp_valid1_q;
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_err    = rsp_err_q;

`ifdef ALU_SHARE_STATS_EN
  logic [15:0] grant_cnt0_q, grant_cnt0_d;
  logic [15:0] grant_cnt1_q, grant_cnt1_d;

  // Saturating accept counters.
  always_comb begin
    grant_cnt0_d = grant_cnt0_q;
    grant_cnt1_d = grant_cnt1_q;
    if (acc && !sel && (grant_cnt0_q != 16'hFFFF)) grant_cnt0_d = grant_cnt0_q + 16'd1;
    if (acc &&  sel && (grant_cnt1_q != 16'hFFFF)) grant_cnt1_d = grant_cnt1_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_cnt0_q <= 16'd0;
      grant_cnt1_q <= 16'd0;
    end else begin
      grant_cnt0_q <= grant_cnt0_d;
      grant_cnt1_q <= grant_cnt1_d;
    end
  end

  assign grant_cnt0 = grant_cnt0_q;
  assign grant_cnt1 = grant_cnt1_q;
`endif

endmodule
